mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates I-cache fills, D-cache fills and D-cache evictions onto a single
//   line-wide memory port. Only one transaction is outstanding at a time:
//   IDLE picks a winner, ISSUE holds the memory request until mem_ack_i, and
//   RESP pulses the winner's completion strobe.
//
//   Build option: define MEM_ARB_RR_EN to alternate D/I fills on a tie
//   (D-cache first after reset). Without it, priority is fixed ev > dc > ic.
//
// Ports
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   ic_req_i/ic_addr_i      I-cache fill request (level) / line address
//   ic_valid_o              pulse: rdata_o holds the I-cache fill line
//   dc_req_i/dc_addr_i      D-cache fill request (level) / line address
//   dc_valid_o              pulse: rdata_o holds the D-cache fill line
//   ev_req_i/ev_addr_i      eviction request (level) / line address
//   ev_data_i               eviction line data
//   ev_done_o               pulse: eviction accepted by memory
//   rdata_o                 registered fill data shared by both fill requesters
//   mem_req_o/mem_we_o      memory request (held until ack) / 1 = line write
//   mem_addr_o/mem_wdata_o  memory line address / write data (0 on reads)
//   mem_ack_i/mem_rdata_i   memory completion pulse / read line (same cycle)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_valid_o,
    input  logic              dc_req_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    output logic              dc_valid_o,
    input  logic              ev_req_i,
    input  logic [ADDR_W-1:0] ev_addr_i,
    input  logic [LINE_W-1:0] ev_data_i,
    output logic              ev_done_o,
    output logic [LINE_W-1:0] rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [1:0] ID_IC = 2'd0;
    localparam logic [1:0] ID_DC = 2'd1;
    localparam logic [1:0] ID_EV = 2'd2;

    state_t            r_state;
    logic [1:0]        r_gnt;
    logic              r_mask_vld;   // r_gnt was just served; block it this IDLE cycle
    logic              r_ic_valid;
    logic              r_dc_valid;
    logic              r_ev_done;
    logic [LINE_W-1:0] r_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata;
`ifdef MEM_ARB_RR_EN
    logic              r_last_dc;    // last fill grant went to D-cache
`endif

    logic              w_any;
    logic [1:0]        w_win;
    logic              w_grant;
    logic [ADDR_W-1:0] w_addr;

    // Priority pick first, then the just-served mask. If the priority winner is
    // the requester still finishing its handshake, nobody is granted this cycle:
    // that keeps a continuously-requesting high-priority source from being
    // overtaken just because its request is still visible for one cycle.
    always_comb begin
        w_any = 1'b0;
        w_win = ID_IC;
        if (ev_req_i) begin
            w_any = 1'b1;
            w_win = ID_EV;
        end else if (dc_req_i && ic_req_i) begin
            w_any = 1'b1;
`ifdef MEM_ARB_RR_EN
            w_win = r_last_dc ? ID_IC : ID_DC;
`else
            w_win = ID_DC;
`endif
        end else if (dc_req_i) begin
            w_any = 1'b1;
            w_win = ID_DC;
        end else if (ic_req_i) begin
            w_any = 1'b1;
            w_win = ID_IC;
        end
        w_grant = w_any && !(r_mask_vld && (w_win == r_gnt));
    end

    always_comb begin
        case (w_win)
            ID_EV:   w_addr = ev_addr_i;
            ID_DC:   w_addr = dc_addr_i;
            default: w_addr = ic_addr_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_gnt       <= ID_IC;
            r_mask_vld  <= 1'b0;
            r_ic_valid  <= 1'b0;
            r_dc_valid  <= 1'b0;
            r_ev_done   <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_dc   <= 1'b0;
`endif
        end else begin
            r_ic_valid <= 1'b0;
            r_dc_valid <= 1'b0;
            r_ev_done  <= 1'b0;
            r_mask_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_gnt       <= w_win;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_win == ID_EV);
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= (w_win == ID_EV) ? ev_data_i : '0;
                        r_state     <= ISSUE;
`ifdef MEM_ARB_RR_EN
                        if (w_win != ID_EV)
                            r_last_dc <= (w_win == ID_DC);
`endif
                    end
                end
                ISSUE: begin
                    if (mem_ack_i) begin
                        // Clear write qualifiers so wdata is never non-zero on a read.
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wdata <= '0;
                        if (!r_mem_we)
                            r_rdata <= mem_rdata_i;
                        case (r_gnt)
                            ID_IC:   r_ic_valid <= 1'b1;
                            ID_DC:   r_dc_valid <= 1'b1;
                            ID_EV:   r_ev_done  <= 1'b1;
                            default: ;
                        endcase
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_mask_vld <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ic_valid_o  = r_ic_valid;
    assign dc_valid_o  = r_dc_valid;
    assign ev_done_o   = r_ev_done;
    assign rdata_o     = r_rdata;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter. Expected memory transactions and
//   expected completion pulses are queued when requests are raised, and popped
//   when the memory port acks / the DUT pulses a completion strobe.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 512;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
    } mem_t;

    typedef struct {
        logic [2:0]        kind;   // {ev, dc, ic}
        logic [LINE_W-1:0] rdata;
    } resp_t;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              ic_req_i, dc_req_i, ev_req_i;
    logic [ADDR_W-1:0] ic_addr_i, dc_addr_i, ev_addr_i;
    logic [LINE_W-1:0] ev_data_i;
    logic              ic_valid_o, dc_valid_o, ev_done_o;
    logic [LINE_W-1:0] rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_rdata_i;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_valid_o(ic_valid_o),
        .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_valid_o(dc_valid_o),
        .ev_req_i(ev_req_i), .ev_addr_i(ev_addr_i), .ev_data_i(ev_data_i),
        .ev_done_o(ev_done_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    mem_t        mem_q[$];
    resp_t       resp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ack_cyc = 0;
    int          wcnt = 0;
    int          ack_lat = 2;
    bit          mem_auto = 1'b1;
    int          hold_left = 0;
    int          ic_pulses = 0;
    logic        prev_pulse = 1'b0;
    logic [LINE_W-1:0] model_rdata = '0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: memory responder and response monitor, sampled at negedge.
    task automatic tick();
        mem_t  m;
        resp_t r;
        logic  pulse;
        @(negedge clk_i);
        cyc++;
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
        end else if (mem_auto && mem_req_o) begin
            wcnt++;
            if (wcnt >= ack_lat) begin
                wcnt = 0;
                chk("mem_q_has_entry", LINE_W'(mem_q.size() != 0), LINE_W'(1));
                if (mem_q.size() != 0) begin
                    m = mem_q.pop_front();
                    chk("mem_we", LINE_W'(mem_we_o), LINE_W'(m.we));
                    chk("mem_addr", LINE_W'(mem_addr_o), LINE_W'(m.addr));
                    chk("mem_wdata", mem_wdata_o, m.wdata);
                    mem_rdata_i = m.rdata;
                end
                mem_ack_i = 1'b1;
                ack_cyc   = cyc;
            end
        end
        pulse = ic_valid_o | dc_valid_o | ev_done_o;
        if (pulse) begin
            chk("pulse_one_cycle", LINE_W'(prev_pulse), LINE_W'(0));
            chk("resp_latency", LINE_W'(cyc - ack_cyc), LINE_W'(1));
            chk("resp_q_has_entry", LINE_W'(resp_q.size() != 0), LINE_W'(1));
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                chk("resp_kind", LINE_W'({ev_done_o, dc_valid_o, ic_valid_o}), LINE_W'(r.kind));
                chk("resp_rdata", rdata_o, r.rdata);
            end
            if (ic_valid_o) ic_pulses++;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin
                    ic_req_i = 1'b0;
                    dc_req_i = 1'b0;
                end
            end else begin
                if (ic_valid_o) ic_req_i = 1'b0;
                if (dc_valid_o) dc_req_i = 1'b0;
            end
            if (ev_done_o) ev_req_i = 1'b0;
        end
        prev_pulse = pulse;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        logic timed_out;
        int   n;
        timed_out = 1'b1;
        for (n = 0; n < budget; n++) begin
            tick();
            if (mem_q.size() == 0 && resp_q.size() == 0 && !mem_req_o) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk(tag, LINE_W'(timed_out), LINE_W'(0));
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        wcnt = 0;
        tick();
        tick();
        rst_n_i = 1'b1;
        model_rdata = '0;
    endtask

    task automatic push_mem(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd);
        mem_t m;
        m.we = we; m.addr = a; m.wdata = wd; m.rdata = rd;
        mem_q.push_back(m);
    endtask

    // Fills update the bench's notion of rdata_o; evictions leave it alone.
    task automatic push_resp(input logic [2:0] kind, input logic [LINE_W-1:0] fill);
        resp_t r;
        if (kind != 3'b100) model_rdata = fill;
        r.kind = kind; r.rdata = model_rdata;
        resp_q.push_back(r);
    endtask

    logic [LINE_W-1:0] d_a5, d_ev, d_dc, d_77, d_ic2;
    logic [2:0]        k_ord[4];

    initial begin
        d_a5  = {64{8'hA5}};
        d_ev  = {16{32'hDEAD_BEEF}};
        d_dc  = {32{16'h5A3C}};
        d_77  = {64{8'h77}};
        d_ic2 = {16{32'h1234_5678}};
        rst_n_i = 1'b0;
        ic_req_i = 1'b0; dc_req_i = 1'b0; ev_req_i = 1'b0;
        ic_addr_i = '0; dc_addr_i = '0; ev_addr_i = '0; ev_data_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;

        // Reset state
        do_reset();
        tick();
        chk("rst_mem_req", LINE_W'(mem_req_o), LINE_W'(0));
        chk("rst_mem_we", LINE_W'(mem_we_o), LINE_W'(0));
        chk("rst_mem_addr", LINE_W'(mem_addr_o), LINE_W'(0));
        chk("rst_mem_wdata", mem_wdata_o, '0);
        chk("rst_rdata", rdata_o, '0);
        chk("rst_pulses", LINE_W'({ev_done_o, dc_valid_o, ic_valid_o}), LINE_W'(0));

        // I-cache fill, ack 4 cycles into the request
        ack_lat = 4;
        push_mem(1'b0, 32'h40, '0, d_a5);
        push_resp(3'b001, d_a5);
        ic_addr_i = 32'h40;
        ic_req_i  = 1'b1;
        tick();
        chk("req_latency", LINE_W'(mem_req_o), LINE_W'(1));
        wait_drain("ic_fill_done", 40);
        chk("ic_fill_rdata", rdata_o, d_a5);

        // Eviction beats a same-cycle D-cache fill; rdata untouched by the write
        ack_lat = 2;
        push_mem(1'b1, 32'h100, d_ev, '0);
        push_resp(3'b100, '0);
        push_mem(1'b0, 32'h200, '0, d_dc);
        push_resp(3'b010, d_dc);
        ev_addr_i = 32'h100; ev_data_i = d_ev;
        dc_addr_i = 32'h200;
        ev_req_i = 1'b1;
        dc_req_i = 1'b1;
        wait_drain("ev_dc_done", 60);

        // Both fills held for four grants
        do_reset();
        ack_lat = 1;
`ifdef MEM_ARB_RR_EN
        k_ord[0] = 3'b010; k_ord[1] = 3'b001; k_ord[2] = 3'b010; k_ord[3] = 3'b001;
`else
        k_ord[0] = 3'b010; k_ord[1] = 3'b010; k_ord[2] = 3'b010; k_ord[3] = 3'b010;
`endif
        for (int i = 0; i < 4; i++) begin
            logic [LINE_W-1:0] d;
            d = {16{32'hC000_0000 + 32'(i)}};
            if (k_ord[i] == 3'b010) push_mem(1'b0, 32'h300, '0, d);
            else                    push_mem(1'b0, 32'h400, '0, d);
            push_resp(k_ord[i], d);
        end
        dc_addr_i = 32'h300;
        ic_addr_i = 32'h400;
        hold_left = 4;
        dc_req_i = 1'b1;
        ic_req_i = 1'b1;
        wait_drain("hold4_done", 80);
        chk("hold4_mem_idle", LINE_W'(mem_req_o), LINE_W'(0));

        // Reset while ISSUE, then a late ack for the abandoned read
        mem_auto = 1'b0;
        ic_addr_i = 32'h500;
        ic_req_i  = 1'b1;
        tick();
        tick();
        chk("pre_rst_issue", LINE_W'(mem_req_o), LINE_W'(1));
        ic_req_i = 1'b0;
        do_reset();
        chk("rst_drop_req", LINE_W'(mem_req_o), LINE_W'(0));
        mem_rdata_i = d_77;
        mem_ack_i   = 1'b1;
        tick();
        tick();
        tick();
        chk("late_ack_rdata", rdata_o, '0);
        chk("late_ack_req", LINE_W'(mem_req_o), LINE_W'(0));
        chk("late_ack_pulses", LINE_W'({ev_done_o, dc_valid_o, ic_valid_o}), LINE_W'(0));
        mem_auto = 1'b1;

        // Spurious ack in IDLE, then a normal I-cache fill
        mem_rdata_i = d_77;
        mem_ack_i   = 1'b1;
        tick();
        tick();
        chk("spur_ack_rdata", rdata_o, '0);
        chk("spur_ack_req", LINE_W'(mem_req_o), LINE_W'(0));
        ic_pulses = 0;
        ack_lat = 3;
        push_mem(1'b0, 32'h600, '0, d_ic2);
        push_resp(3'b001, d_ic2);
        ic_addr_i = 32'h600;
        ic_req_i  = 1'b1;
        wait_drain("spur_fill_done", 40);
        tick();
        tick();
        chk("spur_one_ic_pulse", LINE_W'(ic_pulses), LINE_W'(1));
        chk("spur_fill_rdata", rdata_o, d_ic2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
